ibex_l2_register_file_mp: RTL and testbench

Parametrised multi-read-port successor to the single-port L2 flop-based register file, for FPGA/Verilator targets.
- One write port with byte enables; NumReadPorts independent registered read ports with valid flags.
- Write-to-read bypass, optional hardwired-zero entry 0.
- After reset, a sequential init engine clears the array one entry per cycle.
- Sits beside the core as a small scratch/L2 store shared by several requesters.

---
 rtl/ibex_l2_register_file_mp.sv | 155 +++++++++++++++
 tb/tb_ibex_l2_register_file_mp.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_l2_register_file_mp.sv
// ibex_l2_register_file_mp
// Flop-based scratch/L2 store with one byte-enabled write port and
// NumReadPorts registered read ports (1-cycle latency, per-port valid).
// After reset a sequential engine clears one entry per cycle. While it runs,
// init_busy_o is high and all requests are ignored.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), synchronous active-low reset
//   init_busy_o           high while the array is being cleared
//   we_i/waddr_i/wdata_i/wbe_i   write request, address, data, byte enables
//   re_i/raddr_i          per-port read request and packed addresses
//   rdata_o/rvalid_o      per-port packed read data and valid flags
//
// Optional feature (macro IBEX_L2RF_PARITY_EN): one even-parity bit per
// stored byte, plus par_inject_i (inverts byte-0 parity on a write) and
// parity_err_o (per-port error flag, qualified by rvalid_o).
module ibex_l2_register_file_mp #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned NumWords     = 32,
  parameter int unsigned NumReadPorts = 2,
  parameter bit          ZeroReg      = 1'b1,
  localparam int unsigned AddrWidth   = $clog2(NumWords),
  localparam int unsigned NumBytes    = DataWidth / 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  output logic                              init_busy_o,
  input  logic                              we_i,
  input  logic [AddrWidth-1:0]              waddr_i,
  input  logic [DataWidth-1:0]              wdata_i,
  input  logic [NumBytes-1:0]               wbe_i,
  input  logic [NumReadPorts-1:0]           re_i,
  input  logic [NumReadPorts*AddrWidth-1:0] raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
`ifdef IBEX_L2RF_PARITY_EN
  input  logic                              par_inject_i,
  output logic [NumReadPorts-1:0]           parity_err_o,
`endif
  output logic [NumReadPorts-1:0]           rvalid_o
);

  localparam logic [AddrWidth:0]   NumWordsW = (AddrWidth + 1)'(NumWords);
  localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(NumWords - 1);

  typedef enum logic {INIT, READY} state_e;

  state_e                 state, state_next;
  logic [AddrWidth-1:0]   init_cnt;
  logic [DataWidth-1:0]   mem [NumWords];
  logic                   ready;
  logic                   waddr_ok;
  logic                   wr_en;
  logic [DataWidth-1:0]   rd_word [NumReadPorts];
`ifdef IBEX_L2RF_PARITY_EN
  logic [NumBytes-1:0]    par [NumWords];
  logic [NumReadPorts-1:0] err_next;
`endif

  // State register and init counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if ((state == INIT) && (init_cnt == LastAddr)) state_next = READY;
  end

  // Output logic
  always_comb begin
    init_busy_o = (state == INIT);
  end

  assign ready    = (state == READY);
  assign waddr_ok = ({1'b0, waddr_i} < NumWordsW) && !(ZeroReg && (waddr_i == '0));
  // rst_ni gates the write so a request on a reset edge never lands.
  assign wr_en    = rst_ni && ready && we_i && waddr_ok;

  // Storage: init clear takes the port while INIT runs.
  always_ff @(posedge clk_i) begin
    if (rst_ni && (state == INIT)) begin
      mem[init_cnt] <= '0;
`ifdef IBEX_L2RF_PARITY_EN
      par[init_cnt] <= '0;
`endif
    end else if (wr_en) begin
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (wbe_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
`ifdef IBEX_L2RF_PARITY_EN
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (b == 0) begin
          par[waddr_i][0] <= (wbe_i[0] ? ^wdata_i[7:0] : par[waddr_i][0]) ^ par_inject_i;
        end else if (wbe_i[b]) begin
          par[waddr_i][b] <= ^wdata_i[8*b +: 8];
        end
      end
`endif
    end
  end

  // Per-port read data selection, including write-to-read bypass
  always_comb begin
    logic [AddrWidth-1:0] a;
    a = '0;
    for (int unsigned p = 0; p < NumReadPorts; p++) begin
      a          = raddr_i[p*AddrWidth +: AddrWidth];
      rd_word[p] = '0;
`ifdef IBEX_L2RF_PARITY_EN
      err_next[p] = 1'b0;
`endif
      if (({1'b0, a} < NumWordsW) && !(ZeroReg && (a == '0))) begin
        if (wr_en && (waddr_i == a)) begin
          for (int unsigned b = 0; b < NumBytes; b++) begin
            rd_word[p][8*b +: 8] = wbe_i[b] ? wdata_i[8*b +: 8] : mem[a][8*b +: 8];
          end
        end else begin
          rd_word[p] = mem[a];
`ifdef IBEX_L2RF_PARITY_EN
          for (int unsigned b = 0; b < NumBytes; b++) begin
            if ((^mem[a][8*b +: 8]) != par[a][b]) err_next[p] = 1'b1;
          end
`endif
        end
      end
    end
  end

  // Registered read outputs; data holds when a port is not read.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_o  <= '0;
      rvalid_o <= '0;
`ifdef IBEX_L2RF_PARITY_EN
      parity_err_o <= '0;
`endif
    end else begin
      for (int unsigned p = 0; p < NumReadPorts; p++) begin
        rvalid_o[p] <= ready && re_i[p];
        if (ready && re_i[p]) rdata_o[p*DataWidth +: DataWidth] <= rd_word[p];
`ifdef IBEX_L2RF_PARITY_EN
        parity_err_o[p] <= ready && re_i[p] && err_next[p];
`endif
      end
    end
  end

endmodule

// File: tb/tb_ibex_l2_register_file_mp.sv
// Testbench for ibex_l2_register_file_mp: two instances (NumWords=32 and
// NumWords=24) share stimulus; a reference model pushes expected read
// results into a scoreboard that is drained one cycle later.
module tb_ibex_l2_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic        busy, busy24;
  logic [63:0] rdata, rdata24;
  logic [1:0]  rvalid, rvalid24;
`ifdef IBEX_L2RF_PARITY_EN
  logic        pinj;
  logic [1:0]  perr, perr24;
`endif

  always #5 clk = ~clk;

  ibex_l2_register_file_mp #(
    .DataWidth(32), .NumWords(32), .NumReadPorts(2), .ZeroReg(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .init_busy_o(busy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata),
`ifdef IBEX_L2RF_PARITY_EN
    .par_inject_i(pinj), .parity_err_o(perr),
`endif
    .rvalid_o(rvalid)
  );

  ibex_l2_register_file_mp #(
    .DataWidth(32), .NumWords(24), .NumReadPorts(2), .ZeroReg(1'b1)
  ) u_dut24 (
    .clk_i(clk), .rst_ni(rst_n), .init_busy_o(busy24),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata24),
`ifdef IBEX_L2RF_PARITY_EN
    .par_inject_i(pinj), .parity_err_o(perr24),
`endif
    .rvalid_o(rvalid24)
  );

  typedef struct {
    int          d;
    int          p;
    logic        v;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  string       sb_tag[$];
  logic [31:0] m    [2][32];
  logic [31:0] last [2][2];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then compare everything the scoreboard expects now.
  task automatic tick();
    exp_t        e;
    string       t;
    logic        v;
    logic [31:0] dat;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      t   = sb_tag.pop_front();
      v   = (e.d != 0) ? rvalid24[e.p] : rvalid[e.p];
      dat = (e.d != 0) ? rdata24[e.p*32 +: 32] : rdata[e.p*32 +: 32];
      chk({t, "_vld"}, 64'(v), 64'(e.v));
      chk({t, "_data"}, 64'(dat), 64'(e.data));
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) m[d][i] = '0;
      last[d][0] = '0;
      last[d][1] = '0;
    end
  endtask

  // Drive one READY-phase cycle and queue expectations for both instances.
  task automatic issue(input string tag, input logic [1:0] r, input logic [4:0] a0,
                       input logic [4:0] a1, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [3:0] be);
    exp_t        e;
    logic [4:0]  a;
    int          nw;
    logic        wok;
    re = r; raddr = {a1, a0}; we = w; waddr = wa; wdata = wd; wbe = be;
    for (int d = 0; d < 2; d++) begin
      nw  = (d != 0) ? 24 : 32;
      wok = w && (int'(wa) < nw) && (wa != 5'd0);
      for (int p = 0; p < 2; p++) begin
        a = (p != 0) ? a1 : a0;
        if (r[p]) begin
          if ((int'(a) >= nw) || (a == 5'd0)) last[d][p] = '0;
          else if (wok && (wa == a))          last[d][p] = merge(m[d][a], wd, be);
          else                                last[d][p] = m[d][a];
        end
        e.d = d; e.p = p; e.v = r[p]; e.data = last[d][p];
        sb.push_back(e);
        sb_tag.push_back($sformatf("%s_d%0d_p%0d", tag, d, p));
      end
      if (wok) m[d][wa] = merge(m[d][wa], wd, be);
    end
    tick();
    re = '0; we = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n32, n24;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0; re = '0; raddr = '0;
`ifdef IBEX_L2RF_PARITY_EN
    pinj = 1'b0;
`endif
    clear_model();
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_busy24", 64'(busy24), 64'd1);
    chk("rst_rvalid", 64'({rvalid, rvalid24}), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rdata24", rdata24, 64'd0);

    // Release, with requests pending throughout the early INIT cycles.
    rst_n = 1'b1;
    we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_FFFF; wbe = 4'hF; re = 2'b11;
    raddr = {5'd9, 5'd5};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("init_rvalid", 64'({rvalid, rvalid24}), 64'd0);
    end
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 64'({busy, busy24}), 64'b11);
    chk("midrst_rvalid", 64'({rvalid, rvalid24}), 64'd0);
    rst_n = 1'b1;

    n32 = 0; n24 = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy)   n32++;
      if (busy24) n24++;
      if (!busy && !busy24) break;
      if (i == 15) begin we = 1'b0; re = '0; end
      tick();
      if (i < 15) chk("init2_rvalid", 64'({rvalid, rvalid24}), 64'd0);
    end
    chk("init_len32", 64'(n32), 64'd32);
    chk("init_len24", 64'(n24), 64'd24);

    for (int a = 0; a < 32; a++) issue("sweep", 2'b11, 5'(a), 5'(31 - a), 1'b0, '0, '0, '0);

    issue("wr_full", 2'b00, '0, '0, 1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF);
    issue("wr_be",   2'b00, '0, '0, 1'b1, 5'd5, 32'h1122_3344, 4'b0101);
    issue("rd_be",   2'b01, 5'd5, '0, 1'b0, '0, '0, '0);
    chk("rd_be_lit", 64'(rdata[31:0]), 64'h0000_0000_DE22_BE44);
    issue("bypass",  2'b11, 5'd8, 5'd7, 1'b1, 5'd7, 32'hCAFE_F00D, 4'hF);
    chk("bypass_p1_lit", 64'(rdata[63:32]), 64'h0000_0000_CAFE_F00D);
    chk("bypass_p0_lit", 64'(rdata[31:0]), 64'd0);
    issue("hold",    2'b00, 5'd1, 5'd2, 1'b0, '0, '0, '0);
    issue("byp_part", 2'b11, 5'd5, 5'd5, 1'b1, 5'd5, 32'hAABB_CCDD, 4'b0011);
    chk("byp_part_lit", rdata, 64'hDE22_CCDD_DE22_CCDD);
    issue("zero_wr", 2'b00, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF);
    issue("oor_wr",  2'b00, '0, '0, 1'b1, 5'd30, 32'hFFFF_FFFF, 4'hF);
    issue("zero_oor_rd", 2'b11, 5'd0, 5'd30, 1'b0, '0, '0, '0);
    chk("oor24_lit", rdata24, 64'd0);
    chk("oor24_vld_lit", 64'(rvalid24), 64'b11);
    issue("zero_byp", 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234_5678, 4'hF);
    issue("oor_byp",  2'b10, '0, 5'd26, 1'b1, 5'd26, 32'h5555_AAAA, 4'hF);

    for (int i = 0; i < 80; i++) begin
      issue("rand", 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)));
    end

`ifdef IBEX_L2RF_PARITY_EN
    pinj = 1'b1;
    issue("par_wr_bad", 2'b00, '0, '0, 1'b1, 5'd3, 32'h0000_00A5, 4'hF);
    pinj = 1'b0;
    issue("par_rd_bad", 2'b11, 5'd3, 5'd3, 1'b0, '0, '0, '0);
    chk("par_err_set", 64'(perr), 64'b11);
    chk("par_err_set24", 64'(perr24), 64'b11);
    issue("par_wr_good", 2'b00, '0, '0, 1'b1, 5'd3, 32'h0000_00A5, 4'hF);
    issue("par_rd_good", 2'b11, 5'd3, 5'd3, 1'b0, '0, '0, '0);
    chk("par_err_clr", 64'(perr), 64'b00);
    chk("par_err_clr24", 64'(perr24), 64'b00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
